egg_nonce_scheduler: RTL and testbench

- Sequences the egg_core mining layer: accepts a mining job (header, target, nonce range) and issues one core run per nonce.
- Waits for core completion with a watchdog timeout, compares each returned hash against the job target, and reports hits to the payout layer over a valid/ready channel.
- Sits between the Hare/Chest job source and Egg (compute) / Needle (payout).

---
 rtl/trinity_mining_pkg.sv | 19 +
 rtl/hash_target_cmp.sv | 13 +
 rtl/egg_nonce_scheduler.sv | 159 +++++++++++++++
 tb/tb_egg_nonce_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trinity_mining_pkg.sv
// Shared types and default widths for the
// trinity mining layer (Hare/Chest -> Egg -> Needle).
package trinity_mining_pkg;

  localparam int HDR_W   = 512;
  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    REPORT,
    ADVANCE,
    FINISH
  } sched_state_t;

endpackage

// File: rtl/hash_target_cmp.sv
// Unsigned hash <= target compare, kept apart
// so a pipelined version can drop in later.
module hash_target_cmp #(
  parameter int W = 256
) (
  input  logic [W-1:0] hash,
  input  logic [W-1:0] target,
  output logic         hit
);

  assign hit = (hash <= target);

endmodule

// File: rtl/egg_nonce_scheduler.sv
// Walks a nonce range through egg_core, with a
// watchdog per run, and forwards target hits.
module egg_nonce_scheduler #(
  parameter int HDR_W        = trinity_mining_pkg::HDR_W,
  parameter int HASH_W       = trinity_mining_pkg::HASH_W,
  parameter int NONCE_W      = trinity_mining_pkg::NONCE_W,
  parameter int TIMEOUT      = 1024,
  parameter bit STOP_ON_FIND = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [HDR_W-1:0]   job_header,
  input  logic [HASH_W-1:0]  job_target,
  input  logic [NONCE_W-1:0] job_nonce_start,
  input  logic [NONCE_W-1:0] job_nonce_count,
  input  logic               abort,
  output logic               core_start,
  output logic [HDR_W-1:0]   core_header,
  input  logic               core_done,
  input  logic [HASH_W-1:0]  core_hash,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [NONCE_W-1:0] res_nonce,
  output logic [HASH_W-1:0]  res_hash,
  output logic               busy,
  output logic               job_done,
  output logic               err_timeout,
  output logic [NONCE_W-1:0] nonces_tried
);

  import trinity_mining_pkg::*;

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  sched_state_t state_q;
  sched_state_t state_d;

  logic [TW-1:0]      timer_q;
  logic [NONCE_W-1:0] remaining_q;
  logic [HASH_W-1:0]  target_q;
  logic [HASH_W-1:0]  hash_q;
  logic               hit;
  logic               expire;
  logic               unused_hdr_lo;

  // nonce field of the job header is replaced
  assign unused_hdr_lo = ^job_header[NONCE_W-1:0];

  assign job_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign expire    = ((timer_q + TW'(1)) == T_LAST);

  hash_target_cmp #(
    .W(HASH_W)
  ) u_cmp (
    .hash  (hash_q),
    .target(target_q),
    .hit   (hit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (job_valid)
          state_d = (job_nonce_count == '0) ? FINISH : ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (core_done)
          state_d = CHECK;
        else if (expire)
          state_d = FINISH;
      end
      CHECK: state_d = hit ? REPORT : ADVANCE;
      REPORT: begin
        if (res_ready)
          state_d = STOP_ON_FIND ? FINISH : ADVANCE;
      end
      ADVANCE: begin
        if (remaining_q == NONCE_W'(1))
          state_d = FINISH;
        else
          state_d = ISSUE;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE && state_q != FINISH)
      state_d = FINISH;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      remaining_q  <= '0;
      target_q     <= '0;
      hash_q       <= '0;
      core_start   <= 1'b0;
      core_header  <= '0;
      res_valid    <= 1'b0;
      res_nonce    <= '0;
      res_hash     <= '0;
      job_done     <= 1'b0;
      err_timeout  <= 1'b0;
      nonces_tried <= '0;
    end else begin
      state_q    <= state_d;
      // pulses follow the state being entered
      core_start <= (state_d == ISSUE);
      res_valid  <= (state_d == REPORT);
      job_done   <= (state_d == FINISH);
      case (state_q)
        IDLE: begin
          if (job_valid) begin
            target_q     <= job_target;
            remaining_q  <= job_nonce_count;
            nonces_tried <= '0;
            err_timeout  <= 1'b0;
            if (state_d == ISSUE)
              core_header <= {job_header[HDR_W-1:NONCE_W],
                              job_nonce_start};
          end
        end
        ISSUE: timer_q <= '0;
        WAIT: begin
          if (state_d == CHECK) begin
            hash_q       <= core_hash;
            nonces_tried <= nonces_tried + NONCE_W'(1);
          end else if (state_d == FINISH) begin
            if (!abort)
              err_timeout <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        CHECK: begin
          if (state_d == REPORT) begin
            res_nonce <= core_header[NONCE_W-1:0];
            res_hash  <= hash_q;
          end
        end
        ADVANCE: begin
          if (state_d == ISSUE) begin
            remaining_q <= remaining_q - NONCE_W'(1);
            core_header[NONCE_W-1:0] <=
              core_header[NONCE_W-1:0] + NONCE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_egg_nonce_scheduler.sv
// Directed bench for egg_nonce_scheduler with a
// fixed-latency core model and a STOP_ON_FIND twin.
module tb_egg_nonce_scheduler;

  localparam int HDR_W   = 512;
  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               job_valid;
  logic [HDR_W-1:0]   job_header;
  logic [HASH_W-1:0]  job_target;
  logic [NONCE_W-1:0] job_nonce_start;
  logic [NONCE_W-1:0] job_nonce_count;
  logic               abort;
  logic               core_done;
  logic [HASH_W-1:0]  core_hash;
  logic               res_ready;

  logic               job_ready, s_job_ready;
  logic               core_start, s_core_start;
  logic [HDR_W-1:0]   core_header, s_core_header;
  logic               res_valid, s_res_valid;
  logic [NONCE_W-1:0] res_nonce, s_res_nonce;
  logic [HASH_W-1:0]  res_hash, s_res_hash;
  logic               busy, s_busy;
  logic               job_done, s_job_done;
  logic               err_timeout, s_err_timeout;
  logic [NONCE_W-1:0] nonces_tried, s_nonces_tried;

  egg_nonce_scheduler #(
    .TIMEOUT(16), .STOP_ON_FIND(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_header(job_header), .job_target(job_target),
    .job_nonce_start(job_nonce_start),
    .job_nonce_count(job_nonce_count),
    .abort(abort),
    .core_start(core_start), .core_header(core_header),
    .core_done(core_done), .core_hash(core_hash),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_nonce(res_nonce), .res_hash(res_hash),
    .busy(busy), .job_done(job_done),
    .err_timeout(err_timeout), .nonces_tried(nonces_tried)
  );

  egg_nonce_scheduler #(
    .TIMEOUT(16), .STOP_ON_FIND(1'b1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(s_job_ready),
    .job_header(job_header), .job_target(job_target),
    .job_nonce_start(job_nonce_start),
    .job_nonce_count(job_nonce_count),
    .abort(abort),
    .core_start(s_core_start), .core_header(s_core_header),
    .core_done(core_done), .core_hash(core_hash),
    .res_valid(s_res_valid), .res_ready(res_ready),
    .res_nonce(s_res_nonce), .res_hash(s_res_hash),
    .busy(s_busy), .job_done(s_job_done),
    .err_timeout(s_err_timeout), .nonces_tried(s_nonces_tried)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_start, n_jd, n_hs, n_rv, s_start, s_jd;
  logic [31:0] nq[$];
  logic [31:0] hq[$];

  int          lat   = 4;
  bit          en    = 1'b1;
  logic [255:0] mhash = '0;
  logic [511:0] hdr;

  // core model: done pulse `lat` cycles after core_start
  initial begin
    int cd;
    cd = 0;
    core_done = 1'b0;
    core_hash = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          core_done = 1'b1;
          core_hash = mhash;
        end
      end
      if (core_start && en)
        cd = lat;
    end
  end

  task automatic chk(string tag, logic [511:0] got,
                     logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      if (res_valid && res_ready && !abort && rst_n) begin
        n_hs++;
        hq.push_back(res_nonce);
      end
      @(posedge clk);
      #1;
      if (core_start) begin
        n_start++;
        nq.push_back(core_header[31:0]);
      end
      if (job_done) n_jd++;
      if (res_valid) n_rv++;
      if (s_core_start) s_start++;
      if (s_job_done) s_jd++;
    end
  endtask

  task automatic clr();
    n_start = 0; n_jd = 0; n_hs = 0; n_rv = 0;
    s_start = 0; s_jd = 0;
    nq.delete();
    hq.delete();
  endtask

  task automatic submit(logic [31:0] st, logic [31:0] cnt,
                        logic [255:0] tgt);
    job_header      = hdr;
    job_nonce_start = st;
    job_nonce_count = cnt;
    job_target      = tgt;
    job_valid       = 1'b1;
    step(1);
    job_valid       = 1'b0;
  endtask

  task automatic wait_done(string tag, int max);
    int k;
    k = 0;
    while (!job_done && k < max) begin
      step(1);
      k++;
    end
    chk(tag, job_done, 1'b1);
  endtask

  initial begin
    bit stable;
    bit early;
    hdr             = {16{32'h1234_5678}};
    rst_n           = 1'b0;
    job_valid       = 1'b0;
    job_header      = '0;
    job_target      = '0;
    job_nonce_start = '0;
    job_nonce_count = '0;
    abort           = 1'b0;
    res_ready       = 1'b0;
    clr();
    step(3);
    chk("rst_ready", job_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", core_start, 1'b0);
    chk("rst_rv", res_valid, 1'b0);
    chk("rst_jd", job_done, 1'b0);
    chk("rst_tried", nonces_tried, 32'd0);
    chk("rst_err", err_timeout, 1'b0);
    rst_n = 1'b1;
    step(1);

    // hit on every nonce
    clr();
    res_ready = 1'b1;
    lat = 4;
    mhash = 256'h5;
    submit(32'h10, 32'd3, '1);
    chk("t1_start_lat", core_start, 1'b1);
    chk("t1_hdr", core_header, {hdr[511:32], 32'h10});
    wait_done("t1_done", 100);
    chk("t1_nstart", n_start, 3);
    chk("t1_n0", nq[0], 32'h10);
    chk("t1_n1", nq[1], 32'h11);
    chk("t1_n2", nq[2], 32'h12);
    chk("t1_nhs", n_hs, 3);
    chk("t1_h0", hq[0], 32'h10);
    chk("t1_h1", hq[1], 32'h11);
    chk("t1_h2", hq[2], 32'h12);
    chk("t1_njd", n_jd, 1);
    chk("t1_tried", nonces_tried, 32'd3);
    step(1);
    chk("t1_idle", job_ready, 1'b1);

    // no hits
    clr();
    mhash = 256'h1;
    submit(32'h100, 32'd3, '0);
    wait_done("t2_done", 100);
    chk("t2_nstart", n_start, 3);
    chk("t2_nrv", n_rv, 0);
    chk("t2_tried", nonces_tried, 32'd3);
    chk("t2_njd", n_jd, 1);
    step(1);

    // nonce wrap
    clr();
    mhash = '0;
    submit(32'hFFFF_FFFF, 32'd2, '1);
    wait_done("t3_done", 100);
    chk("t3_n0", nq[0], 32'hFFFF_FFFF);
    chk("t3_n1", nq[1], 32'h0);
    chk("t3_hdr_hi", core_header[511:32], hdr[511:32]);
    chk("t3_nhs", n_hs, 2);
    step(1);

    // empty job
    clr();
    submit(32'h5, 32'd0, '1);
    chk("t3e_jd", job_done, 1'b1);
    chk("t3e_start", core_start, 1'b0);
    step(1);
    chk("t3e_ready", job_ready, 1'b1);
    chk("t3e_nstart", n_start, 0);
    chk("t3e_njd", n_jd, 1);

    // backpressure, plus STOP_ON_FIND twin
    clr();
    res_ready = 1'b0;
    mhash = 256'hABC;
    submit(32'h40, 32'd2, '1);
    step(5);
    chk("t4_rv_early", res_valid, 1'b0);
    step(1);
    chk("t4_rv_lat", res_valid, 1'b1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(res_valid && res_nonce == 32'h40 &&
            res_hash == 256'hABC && !core_start))
        stable = 1'b0;
      step(1);
    end
    chk("t4_stable", stable, 1'b1);
    chk("t4_nstart", n_start, 1);
    res_ready = 1'b1;
    step(1);
    chk("t4_rv_drop", res_valid, 1'b0);
    chk("t4_stop_jd", s_job_done, 1'b1);
    step(1);
    chk("t4_resume", core_start, 1'b1);
    chk("t4_next_nonce", core_header[31:0], 32'h41);
    chk("t4_stop_nostart", s_core_start, 1'b0);
    wait_done("t4_done", 100);
    chk("t4_nhs", n_hs, 2);
    chk("t4_stop_njd", s_jd, 1);
    chk("t4_stop_nstart", s_start, 1);
    step(1);

    // watchdog expiry
    clr();
    en = 1'b0;
    res_ready = 1'b0;
    submit(32'h7, 32'd1, '1);
    early = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (job_done) early = 1'b1;
    end
    chk("t5_early", early, 1'b0);
    step(1);
    chk("t5_jd", job_done, 1'b1);
    chk("t5_err", err_timeout, 1'b1);
    chk("t5_tried", nonces_tried, 32'd0);
    step(1);

    // done in the expiry cycle wins
    clr();
    en = 1'b1;
    lat = 15;
    mhash = 256'h1;
    submit(32'h8, 32'd1, '0);
    chk("t5b_err_clr", err_timeout, 1'b0);
    wait_done("t5b_done", 40);
    chk("t5b_err", err_timeout, 1'b0);
    chk("t5b_tried", nonces_tried, 32'd1);
    chk("t5b_njd", n_jd, 1);
    step(1);

    // abort in WAIT, late done ignored
    clr();
    lat = 6;
    submit(32'h20, 32'd2, '1);
    step(2);
    abort = 1'b1;
    step(1);
    chk("t6a_jd", job_done, 1'b1);
    abort = 1'b0;
    step(6);
    chk("t6a_tried", nonces_tried, 32'd0);
    chk("t6a_nstart", n_start, 1);
    chk("t6a_njd", n_jd, 1);
    chk("t6a_nrv", n_rv, 0);
    chk("t6a_err", err_timeout, 1'b0);
    chk("t6a_ready", job_ready, 1'b1);

    // abort beats res_ready in REPORT
    clr();
    lat = 4;
    mhash = 256'h2;
    submit(32'h30, 32'd2, '1);
    step(6);
    chk("t6b_rv", res_valid, 1'b1);
    res_ready = 1'b1;
    abort = 1'b1;
    step(1);
    chk("t6b_jd", job_done, 1'b1);
    chk("t6b_rv_drop", res_valid, 1'b0);
    abort = 1'b0;
    res_ready = 1'b0;
    chk("t6b_nhs", n_hs, 0);
    chk("t6b_tried", nonces_tried, 32'd1);
    step(1);

    // reset while in REPORT
    clr();
    submit(32'h50, 32'd1, '1);
    step(6);
    chk("t6c_rv", res_valid, 1'b1);
    rst_n = 1'b0;
    step(1);
    chk("t6c_rv0", res_valid, 1'b0);
    chk("t6c_start0", core_start, 1'b0);
    chk("t6c_jd0", job_done, 1'b0);
    chk("t6c_busy0", busy, 1'b0);
    chk("t6c_tried0", nonces_tried, 32'd0);
    chk("t6c_nonce0", res_nonce, 32'd0);
    chk("t6c_hash0", res_hash, 256'd0);
    chk("t6c_hdr0", core_header, 512'd0);
    chk("t6c_err0", err_timeout, 1'b0);
    rst_n = 1'b1;
    step(1);
    chk("t6c_ready", job_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
